seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Reader side of the team's 7-segment display path: passively snoops a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and recovers the displayed hex digits.
- Inputs are synchronised and stability-filtered; each digit is decoded back to 4-bit hex; a complete multi-digit frame is presented with a one-cycle valid pulse.
- Intended use: self-check of display drivers on-chip and the loopback bench for the hex-to-segment encoders.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical synchronised samples required to accept a digit (2..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- an  input  DIGITS  anode enables, active-low; bit i selects digit i.
- frame  output  4*DIGITS  captured hex digits; digit i at [4i+3:4i]; updates only on frame_valid.
- frame_valid  output  1  one-cycle pulse: frame updated with all digits accepted since the last frame.
- accept  output  1  one-cycle pulse: one digit accepted this cycle.
- accept_idx  output  3  index of the digit accepted; valid with accept.
- accept_hex  output  4  decoded value of the digit accepted; valid with accept.
- bad_pattern  output  1  sticky: a stable pattern matched no table entry; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): all outputs 0; sync flops, run counter, partial-frame buffer and seen-mask cleared; state WAIT.
- Decode table, active-low, a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. All other patterns are invalid.
- Synchronisation: {an, seg} passes through two flop stages. All further logic uses stage-2 values (s_an, s_seg).
- Run counter: reloads to 1 when {s_an, s_seg} differs from its previous-cycle value. Otherwise it increments, saturating at STABLE_CYCLES.
- State WAIT: entered on any change, or when s_an is not exactly one-hot-low (all-high, or more than one low = blanking/ghosting). No acceptance in WAIT.
- WAIT -> COUNT: s_an is one-hot-low.
- COUNT -> HELD: run counter reaches STABLE_CYCLES.
  - Transition edge with a valid pattern: accept=1, accept_idx=i, accept_hex=decoded value; buffer[i] <= value; seen[i] <= 1.
  - Transition edge with an invalid pattern: bad_pattern <= 1; no accept; seen unchanged.
- HELD -> WAIT: any change of {s_an, s_seg}. A held value is never accepted twice.
- Latency: E0 = first edge sampling a new stable value. accept is asserted in the cycle after edge E0+STABLE_CYCLES+1 (2 sync edges + STABLE_CYCLES-1 further matching edges).
- Frame: when an accept makes seen all-ones:
  - frame <= buffer, with the just-accepted digit included in the same edge;
  - frame_valid pulses in the same cycle as that accept;
  - seen clears to 0.
- Re-accepting a digit already in seen overwrites buffer[i]; no frame is produced until all digits are seen.
- Out-of-range anode: when DIGITS<8, accept_idx upper bits are 0. Anode index width is internal; DIGITS=1 means every accept also pulses frame_valid.
- Mid-operation reset: immediate clear; partial frame discarded; frame returns to 0.

Test Plan:
- Single digit, DIGITS=4, STABLE_CYCLES=4: hold an=1110, seg=0010010 for 10 cycles -> exactly one accept pulse, 6 cycles after first sampling edge (edge E0+5), accept_idx=0, accept_hex=2; no frame_valid.
- Full scan: cycle digits 0..3 with patterns for 1, A, 7, F, each held 8 cycles -> four accepts in order; frame_valid with the 4th accept; frame=16'hF7A1.
- Glitch rejection: hold pattern "8" for 3 cycles, then "0" for 8 cycles on the same anode -> single accept with hex=0; no accept for 8.
- Ghosting/blanking: an=1100 or an=1111 held 20 cycles -> no accept, bad_pattern stays 0. Then an=1011, seg=1111111 held 8 cycles -> bad_pattern=1, no accept.
- Reset mid-frame: accept digits 0..2, pulse rst_n low for 1 cycle, then scan all four -> frame_valid only after all four post-reset accepts; bad_pattern and frame were 0 after reset.
- Loopback with the hex encoder: drive all 16 hex values through the encoder into seg on digit 1 -> accept_hex equals the driven value for every code.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: snoops a multiplexed active-low 7-segment bus and recovers the displayed hex frame.
module seg_scan_capture #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   frame,
   output logic                  frame_valid,
   output logic                  accept,
   output logic [2:0]            accept_idx,
   output logic [3:0]            accept_hex,
   output logic                  bad_pattern
);
   localparam int W = DIGITS + 7;
   typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;
   state_t                r_state;
   logic [W-1:0]          r_s1, r_s2, r_prev;
   logic [7:0]            r_cnt;
   logic [4*DIGITS-1:0]   r_buf;
   logic [DIGITS-1:0]     r_seen;
   logic [DIGITS-1:0]     w_an, w_seen_nxt;
   logic [6:0]            w_seg;
   logic [7:0]            w_cnt_nxt;
   logic                  w_chg, w_onehot, w_fire, w_valid, w_full, w_take;
   logic [3:0]            w_hex;
   logic [2:0]            w_idx;
   logic [4*DIGITS-1:0]   w_buf_nxt;
   assign w_an       = ~r_s2[W-1:7];
   assign w_seg      = r_s2[6:0];
   assign w_chg      = r_s2 != r_prev;
   assign w_onehot   = (w_an != '0) && ((w_an & (w_an - DIGITS'(1))) == '0);
   assign w_cnt_nxt  = w_chg ? 8'd1 : (r_cnt == 8'(STABLE_CYCLES) ? r_cnt : r_cnt + 8'd1);
   // a held value never fires again until the bus changes
   assign w_fire     = !w_chg && w_onehot && r_state != HELD && w_cnt_nxt == 8'(STABLE_CYCLES);
   assign w_take     = w_fire && w_valid;
   assign w_seen_nxt = r_seen | w_an;
   assign w_full     = &w_seen_nxt;
   always_comb begin
      w_hex   = 4'h0;
      w_valid = 1'b1;
      case (w_seg)
         7'b0000001: w_hex = 4'h0;
         7'b1001111: w_hex = 4'h1;
         7'b0010010: w_hex = 4'h2;
         7'b0000110: w_hex = 4'h3;
         7'b1001100: w_hex = 4'h4;
         7'b0100100: w_hex = 4'h5;
         7'b0100000: w_hex = 4'h6;
         7'b0001111: w_hex = 4'h7;
         7'b0000000: w_hex = 4'h8;
         7'b0000100: w_hex = 4'h9;
         7'b0001000: w_hex = 4'hA;
         7'b1100000: w_hex = 4'hB;
         7'b0110001: w_hex = 4'hC;
         7'b1000010: w_hex = 4'hD;
         7'b0110000: w_hex = 4'hE;
         7'b0111000: w_hex = 4'hF;
         default:    w_valid = 1'b0;
      endcase
   end
   always_comb begin
      w_idx     = 3'd0;
      w_buf_nxt = r_buf;
      for (int i = 0; i < DIGITS; i++)
         if (w_an[i]) begin
            w_idx                = 3'(i);
            w_buf_nxt[4*i +: 4] = w_hex;
         end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1        <= '0;
         r_s2        <= '0;
         r_prev      <= '0;
         r_cnt       <= '0;
         r_state     <= WAIT;
         r_buf       <= '0;
         r_seen      <= '0;
         frame       <= '0;
         frame_valid <= 1'b0;
         accept      <= 1'b0;
         accept_idx  <= '0;
         accept_hex  <= '0;
         bad_pattern <= 1'b0;
      end else begin
         r_s1        <= {an, seg};
         r_s2        <= r_s1;
         r_prev      <= r_s2;
         r_cnt       <= w_cnt_nxt;
         r_state     <= (w_chg || !w_onehot) ? WAIT : w_fire ? HELD : r_state == WAIT ? COUNT : r_state;
         accept      <= w_take;
         frame_valid <= w_take && w_full;
         if (w_take) begin
            accept_idx <= w_idx;
            accept_hex <= w_hex;
            r_buf      <= w_buf_nxt;
            r_seen     <= w_full ? '0 : w_seen_nxt;
            if (w_full) frame <= w_buf_nxt;
         end
         if (w_fire && !w_valid) bad_pattern <= 1'b1;
      end
   end
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed checks of digit acceptance, framing, filtering and reset.
module tb_seg_scan_capture;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [6:0]  seg = 7'h7F;
   logic [3:0]  an = 4'hF;
   logic [15:0] frame;
   logic        frame_valid, accept, bad_pattern;
   logic [2:0]  accept_idx;
   logic [3:0]  accept_hex;
   int checks = 0, errors = 0, cyc = 0, t0 = 0;
   int n_acc = 0, n_fv = 0, last_cyc = 0, a0 = 0, f0 = 0;
   logic [2:0]  last_idx = '0, fv_idx = '0;
   logic [3:0]  last_hex = '0;
   logic [15:0] hhist = '0;
   logic [11:0] ihist = '0;
   logic [6:0]  enc [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   seg_scan_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .frame(frame),
      .frame_valid(frame_valid), .accept(accept), .accept_idx(accept_idx),
      .accept_hex(accept_hex), .bad_pattern(bad_pattern));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (accept) begin
         n_acc    = n_acc + 1;
         last_idx = accept_idx;
         last_hex = accept_hex;
         last_cyc = cyc;
         hhist    = {hhist[11:0], accept_hex};
         ihist    = {ihist[8:0], accept_idx};
      end
      if (frame_valid) begin
         n_fv   = n_fv + 1;
         fv_idx = accept ? accept_idx : 3'd7;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      @(posedge clk);
      #1;
      an = a;
      seg = s;
      t0 = cyc;
      repeat (n - 1) @(posedge clk);
   endtask
   task automatic idle(input int n);
      hold(4'hF, 7'h7F, n);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_frame", frame, 0);
      chk("reset_outputs", {frame_valid, accept, accept_idx, accept_hex, bad_pattern}, 0);
      #1 rst_n = 1'b1;
      idle(10);
      // single digit: one accept, visible in cycle t0+6
      hold(4'b1110, 7'b0010010, 10);
      a0 = t0;
      idle(8);
      chk("single_count", n_acc, 1);
      chk("single_idx", last_idx, 0);
      chk("single_hex", last_hex, 2);
      chk("single_latency", last_cyc, a0 + 6);
      chk("single_no_frame", n_fv, 0);
      // full scan 1, A, 7, F
      a0 = n_acc;
      hold(4'b1110, enc[1], 8);
      hold(4'b1101, enc[10], 8);
      hold(4'b1011, enc[7], 8);
      hold(4'b0111, enc[15], 8);
      idle(8);
      chk("scan_count", n_acc - a0, 4);
      chk("scan_hex_order", hhist, 16'h1A7F);
      chk("scan_idx_order", ihist, 12'b000_001_010_011);
      chk("scan_fv_count", n_fv, 1);
      chk("scan_fv_with_acc", fv_idx, 3);
      chk("scan_frame", frame, 16'hF7A1);
      // glitch: short 8 then stable 0
      a0 = n_acc;
      hold(4'b1011, 7'b0000000, 3);
      hold(4'b1011, 7'b0000001, 8);
      idle(8);
      chk("glitch_count", n_acc - a0, 1);
      chk("glitch_hex", last_hex, 0);
      chk("glitch_idx", last_idx, 2);
      // ghosting, blanking, then an invalid pattern
      a0 = n_acc;
      hold(4'b1100, 7'b0010010, 20);
      hold(4'b1111, 7'b0000000, 20);
      chk("ghost_no_acc", n_acc - a0, 0);
      chk("ghost_no_bad", bad_pattern, 0);
      hold(4'b1011, 7'b1111111, 8);
      idle(8);
      chk("invalid_bad", bad_pattern, 1);
      chk("invalid_no_acc", n_acc - a0, 0);
      chk("invalid_frame_kept", frame, 16'hF7A1);
      // partial frame then reset
      hold(4'b1110, enc[9], 8);
      hold(4'b1101, enc[9], 8);
      hold(4'b1011, enc[9], 8);
      idle(8);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_frame", frame, 0);
      chk("rst_bad", bad_pattern, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      a0 = n_acc;
      f0 = n_fv;
      hold(4'b1110, enc[3], 8);
      hold(4'b1101, enc[5], 8);
      hold(4'b1011, enc[12], 8);
      idle(8);
      chk("rst_no_early_frame", n_fv - f0, 0);
      chk("rst_frame_still0", frame, 0);
      hold(4'b0111, enc[13], 8);
      idle(8);
      chk("rst_scan_count", n_acc - a0, 4);
      chk("rst_fv_count", n_fv - f0, 1);
      chk("rst_frame_new", frame, 16'hDC53);
      // encoder loopback on digit 1
      a0 = n_acc;
      for (int v = 0; v < 16; v++) begin
         hold(4'b1101, enc[v], 8);
         chk("loop_hex", {28'd0, last_hex}, v);
      end
      idle(8);
      chk("loop_count", n_acc - a0, 16);
      chk("loop_idx", last_idx, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
